// File: rtl/tinyml_cam_scale_up_nn.sv
// Nearest-neighbour upscaler for the 2-pixel-per-clock RGB path.
// Integer factor SCALE (1, 2, 4) on both axes: each input beat is replicated
// SCALE times horizontally while live, then the stored line is replayed
// SCALE-1 more times from a line buffer. Output is valid/ready backpressured.
// Optional macro TINYML_SCALE_UP_EOL_EN adds the out_eol port.
module tinyml_cam_scale_up_nn #(
    parameter int P_DEPTH        = 8,
    parameter int IN_FRAME_WIDTH = 540,
    parameter int SCALE          = 2,
    parameter int AW             = $clog2(IN_FRAME_WIDTH/2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2*P_DEPTH-1:0] in_red,
    input  logic [2*P_DEPTH-1:0] in_green,
    input  logic [2*P_DEPTH-1:0] in_blue,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*P_DEPTH-1:0] out_red,
    output logic [2*P_DEPTH-1:0] out_green,
    output logic [2*P_DEPTH-1:0] out_blue,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef TINYML_SCALE_UP_EOL_EN
    ,
    output logic                 out_eol
`endif
);

    localparam int W  = IN_FRAME_WIDTH/2;
    localparam int CW = 2*P_DEPTH;
    localparam int DW = 3*CW;
    localparam int HW = (SCALE > 1) ? $clog2(SCALE) : 1;

    generate
        if (!(SCALE == 1 || SCALE == 2 || SCALE == 4)) begin : g_bad_scale
            $error("SCALE must be 1, 2 or 4");
        end
        if ((IN_FRAME_WIDTH % 2) != 0 || IN_FRAME_WIDTH < 4 || IN_FRAME_WIDTH > 1024) begin : g_bad_width
            $error("IN_FRAME_WIDTH must be even, 4..1024");
        end
    endgenerate

    typedef enum logic {LIVE, REPLAY} state_t;

    state_t          state, state_n;
    logic [AW-1:0]   wr_addr, rd_addr, rd_addr_n;
    logic [HW-1:0]   row_cnt, row_cnt_n;
    logic [HW-1:0]   hphase;
    logic [DW-1:0]   src;          // beat whose replicas are being emitted
    logic [DW-1:0]   out_q;
    logic [DW-1:0]   rd_q;         // prefetched line-buffer word at rd_addr
    logic [DW-1:0]   mem [0:W-1];
    logic [DW-1:0]   in_beat;
    logic            free, accept, rd_load, ld;
    logic [DW-1:0]   ld_beat;
    logic [HW-1:0]   ld_k;
`ifdef TINYML_SCALE_UP_EOL_EN
    logic            src_last, ld_last, eol_q;
`endif

    assign in_beat   = {in_blue, in_green, in_red};
    assign free      = out_ready | ~out_valid;
    assign in_ready  = rst_n & (state == LIVE) & (hphase == '0) & free;
    assign accept    = in_valid & in_ready;
    assign rd_load   = (SCALE > 1) & (state == REPLAY) & (hphase == '0) & free;
    assign out_red   = out_q[CW-1:0];
    assign out_green = out_q[2*CW-1:CW];
    assign out_blue  = out_q[3*CW-1:2*CW];
`ifdef TINYML_SCALE_UP_EOL_EN
    assign out_eol   = eol_q;
`endif

    // Replica k of a beat: low pixel for the first half of the replicas,
    // high pixel for the second half, duplicated into both output slots.
    function automatic logic [DW-1:0] rep_beat(input logic [DW-1:0] b, input logic [HW-1:0] k);
        logic [DW-1:0]      r;
        logic [P_DEPTH-1:0] px;
        r = b;
        if (SCALE > 1) begin
            for (int c = 0; c < 3; c++) begin
                px = (int'(k) >= SCALE/2) ? b[c*CW+P_DEPTH +: P_DEPTH] : b[c*CW +: P_DEPTH];
                r[c*CW +: CW] = {px, px};
            end
        end
        return r;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= LIVE;
        else        state <= state_n;
    end

    // Next state and replay read-address / row bookkeeping.
    always_comb begin
        state_n   = state;
        rd_addr_n = rd_addr;
        row_cnt_n = row_cnt;
        if (accept && wr_addr == AW'(W-1) && SCALE > 1)
            state_n = REPLAY;
        if (rd_load) begin
            if (rd_addr == AW'(W-1)) begin
                rd_addr_n = '0;
                if (int'(row_cnt) == SCALE-2) begin
                    row_cnt_n = '0;
                    state_n   = LIVE;
                end else begin
                    row_cnt_n = row_cnt + HW'(1);
                end
            end else begin
                rd_addr_n = rd_addr + AW'(1);
            end
        end
    end

    // Pick what the output register loads next: pending replicas first,
    // then a fresh input beat (live) or the prefetched RAM word (replay).
    always_comb begin
        ld      = 1'b0;
        ld_beat = src;
        ld_k    = hphase;
`ifdef TINYML_SCALE_UP_EOL_EN
        ld_last = src_last;
`endif
        if (hphase != '0 && free) begin
            ld = 1'b1;
        end else if (accept) begin
            ld      = 1'b1;
            ld_beat = in_beat;
            ld_k    = '0;
`ifdef TINYML_SCALE_UP_EOL_EN
            ld_last = (wr_addr == AW'(W-1));
`endif
        end else if (rd_load) begin
            ld      = 1'b1;
            ld_beat = rd_q;
            ld_k    = '0;
`ifdef TINYML_SCALE_UP_EOL_EN
            ld_last = (rd_addr == AW'(W-1));
`endif
        end
    end

    // Output register, replica phase, write/read addresses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr   <= '0;
            rd_addr   <= '0;
            row_cnt   <= '0;
            hphase    <= '0;
            src       <= '0;
            out_q     <= '0;
            out_valid <= 1'b0;
`ifdef TINYML_SCALE_UP_EOL_EN
            src_last  <= 1'b0;
            eol_q     <= 1'b0;
`endif
        end else begin
            rd_addr <= rd_addr_n;
            row_cnt <= row_cnt_n;
            if (accept)
                wr_addr <= (wr_addr == AW'(W-1)) ? '0 : wr_addr + AW'(1);
            if (free) begin
                out_valid <= ld;
                if (ld) begin
                    out_q <= rep_beat(ld_beat, ld_k);
`ifdef TINYML_SCALE_UP_EOL_EN
                    eol_q <= ld_last & (int'(ld_k) == SCALE-1);
`endif
                end
            end
            if (ld && SCALE > 1) begin
                hphase <= (int'(ld_k) == SCALE-1) ? '0 : ld_k + HW'(1);
                if (ld_k == '0) begin
                    src <= ld_beat;
`ifdef TINYML_SCALE_UP_EOL_EN
                    src_last <= ld_last;
`endif
                end
            end
        end
    end

    // Line buffer. The read address only moves on a load, so while the
    // output stalls the prefetched word stays the same.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_addr] <= in_beat;
        rd_q <= mem[rd_addr_n];
    end

endmodule
